// File: rtl/rf_ctrl_pkg.sv
// Shared types and constants for the register-file shift sequencer.
package rf_ctrl_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // shift_ctl is {dir, arith}
    localparam logic [1:0] SH_SLL = 2'b00;
    localparam logic [1:0] SH_SRL = 2'b10;
    localparam logic [1:0] SH_SRA = 2'b11;

endpackage

// File: rtl/rf_pass_counter.sv
// Down-counter for shift passes; last flags the final pass (count == 1).
module rf_pass_counter #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         last
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == W'(1));

endmodule

// File: rtl/rf_shift_seq.sv
// Sequences multi-bit shifts as repeated one-bit passes through the register file.
// Optional cycle counter: define RF_SHIFT_SEQ_PERF_CNT_EN to add perf_cycles.
//
// state | meaning
// IDLE  | waiting for start; all register-file controls quiet
// SHIFT | one one-bit pass per cycle into rd
// DONE  | one-cycle completion pulse, then back to IDLE
module rf_shift_seq
    import rf_ctrl_pkg::*;
#(
    parameter int SHAMT_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [REG_IDX_W-1:0] rs1_idx,
    input  logic [REG_IDX_W-1:0] rd_idx,
    input  logic [SHAMT_W-1:0]   shamt,
    input  logic [1:0]           shift_ctl,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 zero_nop,
    output logic [REG_IDX_W-1:0] rf_rd_index,
    output logic [REG_IDX_W-1:0] rf_rs1_index,
    output logic [REG_IDX_W-1:0] rf_rs2_index,
    output logic                 rf_write_en,
    output logic                 rf_data2bus_en,
    output logic                 rf_shift_en,
    output logic                 rf_exp_go_dn,
    output logic                 rf_op_enable,
    output logic [1:0]           rf_shift_controls
`ifdef RF_SHIFT_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]          perf_cycles
`endif
);

    state_t               state_q;
    state_t               state_d;
    logic [REG_IDX_W-1:0] rs1_q;
    logic [REG_IDX_W-1:0] rd_q;
    logic [1:0]           ctl_q;
    logic                 first_q;
    logic                 zero_q;
    logic                 accept;
    logic                 last_pass;
    logic [REG_IDX_W-1:0] src_idx;

    assign accept = (state_q == IDLE) && start;

    rf_pass_counter #(
        .W (SHAMT_W)
    ) u_pass_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (accept),
        .dec      (state_q == SHIFT),
        .load_val (shamt),
        .last     (last_pass)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            rs1_q   <= '0;
            rd_q    <= '0;
            ctl_q   <= SH_SLL;
            first_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                rs1_q   <= rs1_idx;
                rd_q    <= rd_idx;
                ctl_q   <= shift_ctl;
                first_q <= 1'b1;
                zero_q  <= (shamt == '0);
            end else if (state_q == SHIFT) begin
                first_q <= 1'b0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (abort || last_pass) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The first pass reads the source; later passes keep reshifting rd in place.
    assign src_idx = first_q ? rs1_q : rd_q;

    always_comb begin
        rf_rd_index       = '0;
        rf_rs1_index      = '0;
        rf_rs2_index      = '0;
        rf_write_en       = 1'b0;
        rf_data2bus_en    = 1'b0;
        rf_shift_en       = 1'b0;
        rf_exp_go_dn      = 1'b0;
        rf_op_enable      = 1'b0;
        rf_shift_controls = 2'b00;
        if (state_q == SHIFT) begin
            rf_rd_index       = rd_q;
            rf_rs1_index      = src_idx;
            rf_rs2_index      = src_idx;
            rf_write_en       = (rd_q != '0) && !abort;
            rf_data2bus_en    = 1'b1;
            rf_shift_en       = 1'b1;
            rf_exp_go_dn      = 1'b1;
            rf_shift_controls = ctl_q;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == DONE);
    assign zero_nop = (state_q == DONE) && zero_q;

`ifdef RF_SHIFT_SEQ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_cycles <= '0;
        end else if ((state_q == SHIFT) && (perf_cycles != 32'hFFFF_FFFF)) begin
            perf_cycles <= perf_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_rf_shift_seq.sv
// Self-checking bench for rf_shift_seq with a behavioural register-file model.
module tb_rf_shift_seq;
    import rf_ctrl_pkg::*;

    localparam int SHAMT_W = 5;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic [4:0]         rs1_idx = '0;
    logic [4:0]         rd_idx = '0;
    logic [SHAMT_W-1:0] shamt = '0;
    logic [1:0]         shift_ctl = '0;
    logic               busy, done, zero_nop;
    logic [4:0]         rf_rd_index, rf_rs1_index, rf_rs2_index;
    logic               rf_write_en, rf_data2bus_en, rf_shift_en, rf_exp_go_dn, rf_op_enable;
    logic [1:0]         rf_shift_controls;
`ifdef RF_SHIFT_SEQ_PERF_CNT_EN
    logic [31:0]        perf_cycles;
`endif

    rf_shift_seq #(.SHAMT_W(SHAMT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .start             (start),
        .rs1_idx           (rs1_idx),
        .rd_idx            (rd_idx),
        .shamt             (shamt),
        .shift_ctl         (shift_ctl),
        .abort             (abort),
        .busy              (busy),
        .done              (done),
        .zero_nop          (zero_nop),
        .rf_rd_index       (rf_rd_index),
        .rf_rs1_index      (rf_rs1_index),
        .rf_rs2_index      (rf_rs2_index),
        .rf_write_en       (rf_write_en),
        .rf_data2bus_en    (rf_data2bus_en),
        .rf_shift_en       (rf_shift_en),
        .rf_exp_go_dn      (rf_exp_go_dn),
        .rf_op_enable      (rf_op_enable),
        .rf_shift_controls (rf_shift_controls)
`ifdef RF_SHIFT_SEQ_PERF_CNT_EN
        ,
        .perf_cycles       (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          shift_cycles_total = 0;
    logic [31:0] rf [32];

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rd;
        int          shamt;
        logic [1:0]  ctl;
        int          abort_at;   // -1 none; 0 = same cycle as start; k = k-th busy cycle
        bit          start_busy;
        logic [31:0] init;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [24:0] obs();
        return {busy, done, zero_nop, rf_write_en, rf_data2bus_en, rf_shift_en,
                rf_exp_go_dn, rf_op_enable, rf_shift_controls, rf_rd_index,
                rf_rs1_index, rf_rs2_index};
    endfunction

    task automatic check_vec(input string name, input logic [24:0] exp);
        logic [24:0] act;
        act = obs();
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] shift_ref(input logic [31:0] v, input logic [1:0] ctl, input int n);
        logic signed [31:0] s;
        s = v;
        case (ctl)
            SH_SRL:  return v >> n;
            SH_SRA:  return 32'(s >>> n);
            default: return v << n;
        endcase
    endfunction

    function automatic logic [31:0] preset(input logic [4:0] r);
        return 32'h5A00_0000 | 32'(r);
    endfunction

    function automatic bit aborted(input vec_t v);
        return (v.abort_at >= 1) && (v.abort_at <= v.shamt);
    endfunction

    function automatic int busy_shift(input vec_t v);
        return aborted(v) ? v.abort_at : v.shamt;
    endfunction

    // Architectural result in rd from the shift rules alone.
    function automatic logic [31:0] expect_rd(input vec_t v);
        int          w;
        logic [31:0] src;
        w = aborted(v) ? v.abort_at - 1 : v.shamt;
        src = (v.rs1 == 0) ? 32'h0 : v.init;
        if (v.rd == 0) return 32'h0;
        if (w == 0) return (v.rs1 == v.rd) ? src : preset(v.rd);
        return shift_ref(src, v.ctl, w);
    endfunction

    function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rd, input int sh,
                                input logic [1:0] ctl, input int ab, input bit sb,
                                input logic [31:0] init, input logic [31:0] exp_rd);
        vec_t v;
        v.rs1 = rs1; v.rd = rd; v.shamt = sh; v.ctl = ctl;
        v.abort_at = ab; v.start_busy = sb; v.init = init; v.exp_rd = exp_rd;
        return v;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        int          n_eff;
        bit          we;
        logic [4:0]  rs;
        logic [24:0] exp;
        string       nm;
        rf[v.rd] = preset(v.rd);
        if (v.rs1 != 0) rf[v.rs1] = v.init;
        rf[0] = 32'h0;
        n_eff = busy_shift(v);
        for (int c = 0; c <= n_eff + 2; c++) begin
            @(posedge clk);
            #1;
            start = (c == 0) || (v.start_busy && c == 2 && c <= n_eff + 1);
            abort = (c == v.abort_at);
            if (c == 0) begin
                rs1_idx = v.rs1; rd_idx = v.rd; shamt = SHAMT_W'(v.shamt); shift_ctl = v.ctl;
            end else begin
                rs1_idx = 5'($urandom); rd_idx = 5'($urandom);
                shamt = SHAMT_W'($urandom); shift_ctl = 2'($urandom);
            end
            @(negedge clk);
            if (c >= 1 && c <= n_eff) begin
                we = (v.rd != 0) && !(aborted(v) && c == n_eff);
                rs = (c == 1) ? v.rs1 : v.rd;
                exp = {1'b1, 1'b0, 1'b0, we, 1'b1, 1'b1, 1'b1, 1'b0, v.ctl, v.rd, rs, rs};
                shift_cycles_total++;
            end else if (c == n_eff + 1) begin
                exp = {1'b1, 1'b1, (v.shamt == 0), 22'h0};
            end else begin
                exp = 25'h0;
            end
            nm = $sformatf("vec%0d_cyc%0d", idx, c);
            check_vec(nm, exp);
            if (rf_write_en)
                rf[rf_rd_index] = shift_ref(rf[rf_rs2_index], rf_shift_controls, 1);
        end
        start = 1'b0;
        abort = 1'b0;
        check32($sformatf("vec%0d_rd_value", idx), rf[v.rd], v.exp_rd);
        check32($sformatf("vec%0d_x0", idx), rf[0], 32'h0);
    endtask

    initial begin
        logic [1:0] ctls [3];
        vec_t       v;
        int         done_seen;
        ctls[0] = SH_SLL; ctls[1] = SH_SRL; ctls[2] = SH_SRA;
        for (int i = 0; i < 32; i++) rf[i] = 32'h0;

        vecs.push_back(mk(5'd3, 5'd5, 4,  SH_SLL, -1, 1'b0, 32'h0000_0001, 32'h0000_0010));
        vecs.push_back(mk(5'd3, 5'd5, 31, SH_SRA, -1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF));
        vecs.push_back(mk(5'd3, 5'd6, 0,  SH_SRL, -1, 1'b1, 32'h0000_1234, 32'h5A00_0006));
        vecs.push_back(mk(5'd3, 5'd0, 3,  SH_SLL, -1, 1'b0, 32'h0000_0007, 32'h0000_0000));
        vecs.push_back(mk(5'd3, 5'd5, 6,  SH_SRL, 2,  1'b1, 32'h0000_00F0, 32'h0000_0078));
        vecs.push_back(mk(5'd9, 5'd9, 5,  SH_SRA, -1, 1'b0, 32'h8000_0100, 32'hFC00_0008));
        vecs.push_back(mk(5'd1, 5'd2, 3,  SH_SRL, 0,  1'b0, 32'h0000_0080, 32'h0000_0010));
        vecs.push_back(mk(5'd4, 5'd8, 2,  SH_SLL, 3,  1'b0, 32'h0000_0003, 32'h0000_000C));
        vecs.push_back(mk(5'd4, 5'd8, 5,  SH_SLL, 1,  1'b0, 32'h0000_0003, 32'h5A00_0008));
        for (int i = 0; i < 10; i++) begin
            v = mk(5'($urandom), 5'($urandom), int'($urandom % 32), ctls[$urandom % 3],
                   -1, 1'($urandom), $urandom, 32'h0);
            if ($urandom % 3 == 0) v.abort_at = int'($urandom_range(0, v.shamt + 1));
            v.exp_rd = expect_rd(v);
            vecs.push_back(v);
        end

        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check_vec("reset_state", 25'h0);
`ifdef RF_SHIFT_SEQ_PERF_CNT_EN
        check32("reset_perf", perf_cycles, 32'h0);
`endif

        // Abort while idle must not disturb anything.
        @(posedge clk); #1; abort = 1'b1;
        @(negedge clk);
        check_vec("abort_idle", 25'h0);
        @(posedge clk); #1; abort = 1'b0;

        foreach (vecs[i]) run_vec(i, vecs[i]);

`ifdef RF_SHIFT_SEQ_PERF_CNT_EN
        @(negedge clk);
        check32("perf_total", perf_cycles, 32'(shift_cycles_total));
`endif

        // Reset in the middle of a SHIFT sequence.
        @(posedge clk); #1;
        start = 1'b1; rs1_idx = 5'd2; rd_idx = 5'd4; shamt = SHAMT_W'(6); shift_ctl = SH_SLL;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_vec("pre_reset_shift", {1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                      SH_SLL, 5'd4, 5'd4, 5'd4});
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_vec("mid_reset_outputs", 25'h0);
`ifdef RF_SHIFT_SEQ_PERF_CNT_EN
        check32("mid_reset_perf", perf_cycles, 32'h0);
`endif
        done_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        check32("no_done_after_reset", 32'(done_seen), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_shift_seq.md
RF_SHIFT_SEQ -- requirements
Module: rf_shift_seq

Interface
REQ-001 SHALL have parameter SHAMT_W, default 5, meaning the width of the shift amount (maximum shift 2^SHAMT_W-1).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request pulse; it is sampled only in IDLE.
REQ-005 SHALL have ports rs1_idx and rd_idx, input, 5 bits each: source and destination register.
REQ-006 SHALL have port shamt, input, SHAMT_W bits: number of one-bit shift passes.
REQ-007 SHALL have port shift_ctl, input, 2 bits: {dir, arith}, where 00 = SLL, 10 = SRL, 11 = SRA.
REQ-008 SHALL have port abort, input, 1 bit: terminates a running sequence.
REQ-009 SHALL have outputs busy, done and zero_nop, 1 bit each: status, a one-cycle completion pulse, and a flag raised for shamt = 0 requests.
REQ-010 SHALL drive the register file through these outputs: rf_rd_index (5), rf_rs1_index (5), rf_rs2_index (5), rf_write_en, rf_data2bus_en, rf_shift_en, rf_exp_go_dn, rf_op_enable (1 bit each) and rf_shift_controls (2).

Function
REQ-011 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-012 In IDLE, start=1 SHALL latch rs1_idx, rd_idx, shamt and shift_ctl, and SHALL load the pass counter with shamt.
- Next state is SHIFT if shamt != 0, otherwise DONE.
REQ-013 In SHIFT, each cycle SHALL perform one one-bit pass through the downstream shifter into rd:
- rf_data2bus_en = 1, rf_shift_en = 1, rf_exp_go_dn = 1, rf_op_enable = 0.
- rf_rs2_index = latched rs1 on the first pass, latched rd on every later pass.
- rf_rs1_index = rf_rs2_index.
- rf_rd_index = latched rd; rf_write_en = 1.
- rf_shift_controls = latched shift_ctl.
REQ-014 The counter SHALL decrement once per SHIFT cycle; SHIFT SHALL exit to DONE in the cycle the counter reaches 1, so a request occupies exactly shamt SHIFT cycles.
REQ-015 DONE SHALL last one cycle with done = 1, then return to IDLE.
- Total latency from accepting start to the done pulse is shamt + 1 cycles.
REQ-016 busy SHALL equal 1 in SHIFT and DONE, and 0 in IDLE.
REQ-017 Whenever the FSM is not in SHIFT, all rf_* enables SHALL be 0 and all rf_* indices SHALL be 0.
REQ-018 A shamt = 0 request SHALL perform no register-file access and SHALL assert zero_nop together with done; the issuing stage then performs an ordinary move.
REQ-019 A latched rd of 0 SHALL force rf_write_en = 0 for the whole sequence, while timing is unchanged (x0 is never written).
REQ-020 abort=1 in SHIFT SHALL suppress rf_write_en in that same cycle and move to DONE; done pulses next cycle with zero_nop = 0.
- A partially shifted rd is the architecturally accepted result of an abort.
REQ-021 abort in IDLE or DONE SHALL be ignored.
REQ-022 start while busy = 1 SHALL be ignored and produce no queuing.
REQ-023 start and abort arriving together in IDLE SHALL accept the start.
REQ-024 rs1 = rd SHALL be legal; every pass then reads and writes the same row.

Reset
REQ-025 rst = 0 at a clock edge SHALL force IDLE, clear the counter and latched fields, and drive busy, done, zero_nop and all rf_* outputs to 0 on the next cycle.
REQ-026 Reset in mid-sequence SHALL abandon the operation without a done pulse; the contents of rd are then undefined.

Configuration
REQ-027 With macro RF_SHIFT_SEQ_PERF_CNT_EN defined, the block SHALL add output perf_cycles (32 bits).
- It counts cycles spent in SHIFT, saturates at 0xFFFF_FFFF and is cleared by reset.
REQ-028 Without RF_SHIFT_SEQ_PERF_CNT_EN, the port and counter SHALL be absent, and the rest of the behaviour SHALL be identical.

Structure
REQ-029 A shared package rf_ctrl_pkg SHALL hold:
- the state enum (IDLE/SHIFT/DONE);
- the shift_ctl encodings SH_SLL = 2'b00, SH_SRL = 2'b10, SH_SRA = 2'b11;
- REG_IDX_W = 5.
REQ-030 The pass counter SHALL be a sub-module, rf_pass_counter, providing load, decrement and last outputs.
REQ-031 The FSM and output decode SHALL live in rf_shift_seq.

Verification
REQ-032 start with rs1 = 3, rd = 5, shamt = 4, SLL, x3 = 0x0000_0001 -> four SHIFT cycles with rs2 indices 3, 5, 5, 5; done in cycle 5; x5 = 0x0000_0010.
REQ-033 SRA, shamt = 31, x3 = 0x8000_0000 -> x5 = 0xFFFF_FFFF; done 32 cycles after start.
REQ-034 shamt = 0 -> done and zero_nop next cycle, with rf_write_en never asserted.
REQ-035 rd = 0, shamt = 3 -> busy for 4 cycles, rf_write_en = 0 throughout, x0 remains 0.
REQ-036 abort in the 2nd SHIFT cycle of a shamt = 6 request -> one write occurs, done one cycle after the abort, and a second start during busy is ignored.
REQ-037 rst = 0 during SHIFT -> all outputs 0 the next cycle, no done pulse; with RF_SHIFT_SEQ_PERF_CNT_EN defined, perf_cycles = 0.
